// File: rtl/asa_sub_aging_if.sv
// Expiry-event handshake between the subscription aging engine (master)
// and the ASA control logic (slave).
interface asa_sub_aging_if #(
  parameter int IDX_NBITS = 6
);
  logic                 exp_valid;
  logic [IDX_NBITS-1:0] exp_idx;
  logic                 exp_ready;

  modport master (output exp_valid, output exp_idx, input exp_ready);
  modport slave  (input exp_valid, input exp_idx, output exp_ready);
endinterface

// File: rtl/asa_sub_aging.sv
// Subscription aging engine: per-slot lifetime table swept once per aging tick,
// one expiry event per timed-out slot. Optional counters under ASA_AGING_STATS_EN.
`ifndef SUB_EXP_TIME_NBITS
`define SUB_EXP_TIME_NBITS 16
`endif

module asa_sub_aging #(
  parameter int SUB_ENTRIES = 64,
  parameter int IDX_NBITS   = 6,
  parameter int TIME_NBITS  = `SUB_EXP_TIME_NBITS,
  parameter int TICK_DIV    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_div,
  input  logic [TIME_NBITS-1:0] default_sub_exp_time,
  input  logic                  upd_valid,
  input  logic                  upd_op,
  input  logic [IDX_NBITS-1:0]  upd_idx,
  input  logic [TIME_NBITS-1:0] upd_time,
  input  logic [IDX_NBITS-1:0]  rd_idx,
  output logic                  rd_valid,
  output logic [TIME_NBITS-1:0] rd_time,
  asa_sub_aging_if.master       exp,
  output logic                  busy
`ifdef ASA_AGING_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [31:0]           exp_cnt,
  output logic [15:0]           tick_drop_cnt
`endif
);

  localparam int PRE_NBITS = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_NBITS-1:0] PRE_LAST = PRE_NBITS'(TICK_DIV - 1);
  localparam logic [IDX_NBITS-1:0] IDX_LAST = IDX_NBITS'(SUB_ENTRIES - 1);
  localparam logic [TIME_NBITS-1:0] ONE     = TIME_NBITS'(1);

  typedef enum logic [1:0] {IDLE, SWEEP, EMIT} state_t;

  state_t                 state_q;
  logic [IDX_NBITS-1:0]   idx_q;
  logic                   tick_pend_q;
  logic [PRE_NBITS-1:0]   pre_cnt_q;
  logic [SUB_ENTRIES-1:0] valid_q;
  logic [TIME_NBITS-1:0]  life_q [SUB_ENTRIES];

  logic                  tick;
  logic                  exp_hs;
  logic                  slot_hit;
  logic                  sweep_dec;
  logic                  sweep_exp;
  logic [TIME_NBITS-1:0] cur_life;
  logic [TIME_NBITS-1:0] upd_life;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tick      = clk_div && (pre_cnt_q == PRE_LAST);
    exp_hs    = (state_q == EMIT) && exp.exp_ready;
    cur_life  = life_q[idx_q];
    upd_life  = (upd_time == '0) ? default_sub_exp_time : upd_time;
    // A same-cycle update to the swept slot wins: the sweep leaves that slot alone.
    slot_hit  = upd_valid && (upd_idx == idx_q);
    sweep_dec = 1'b0;
    sweep_exp = 1'b0;
    if ((state_q == SWEEP) && !slot_hit && valid_q[idx_q]) begin
      sweep_dec = (cur_life > ONE);
      sweep_exp = (cur_life == ONE);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else if (clk_div) begin
      pre_cnt_q <= (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + 1'b1;
    end
  end

  // NOTE: the table must be cleared by reset, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < SUB_ENTRIES; i++) life_q[i] <= '0;
    end else begin
      if (sweep_dec) life_q[idx_q] <= cur_life - ONE;
      if (sweep_exp) begin
        valid_q[idx_q] <= 1'b0;
        life_q[idx_q]  <= '0;
      end
      if (upd_valid) begin
        valid_q[upd_idx] <= upd_op;
        life_q[upd_idx]  <= upd_op ? upd_life : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_time  <= '0;
    end else begin
      rd_valid <= valid_q[rd_idx];
      rd_time  <= life_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      tick_pend_q   <= 1'b0;
      busy          <= 1'b0;
      exp.exp_valid <= 1'b0;
      exp.exp_idx   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A tick coinciding with a pending one merges into this sweep.
          if (tick || tick_pend_q) begin
            state_q     <= SWEEP;
            idx_q       <= '0;
            tick_pend_q <= 1'b0;
            busy        <= 1'b1;
          end
        end
        SWEEP: begin
          if (tick) tick_pend_q <= 1'b1;
          if (sweep_exp) begin
            exp.exp_valid <= 1'b1;
            exp.exp_idx   <= idx_q;
            state_q       <= EMIT;
          end else if (idx_q == IDX_LAST) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        EMIT: begin
          if (tick) tick_pend_q <= 1'b1;
          if (exp_hs) begin
            exp.exp_valid <= 1'b0;
            if (idx_q == IDX_LAST) begin
              state_q <= IDLE;
              busy    <= 1'b0;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= SWEEP;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ASA_AGING_STATS_EN
  logic tick_drop;
  assign tick_drop = tick && tick_pend_q;

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      exp_cnt       <= '0;
      tick_drop_cnt <= '0;
    end else begin
      if (exp_hs && (exp_cnt != '1))             exp_cnt       <= exp_cnt + 1'b1;
      if (tick_drop && (tick_drop_cnt != '1))    tick_drop_cnt <= tick_drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/asa_sub_aging.md
Name: asa_sub_aging

Overview:
- Subscription aging engine sitting directly downstream of the ASA register block.
- Consumes default_sub_exp_time and the clk_div timebase.
- Holds a per-subscription remaining-lifetime table and sweeps it once per aging tick.
- Emits one expiry event per timed-out subscription to the ASA control logic over a valid/ready handshake.

Parameters:
- SUB_ENTRIES, 64, number of subscription slots (power of two).
- IDX_NBITS, 6, log2(SUB_ENTRIES).
- TIME_NBITS, `SUB_EXP_TIME_NBITS, width of the lifetime counter, in aging ticks.
- TICK_DIV, 1024, clk_div pulses per aging tick.

Ports:
- clk  in  1  core clock.
- `RESET_SIG  in  1  reset; synchronous, active-high.
- clk_div  in  1  single-cycle timebase pulse, shared with the PIO logic.
- default_sub_exp_time  in  TIME_NBITS  lifetime used when an update carries time 0.
- upd_valid  in  1  table update strobe; always accepted.
- upd_op  in  1  1 = set/refresh, 0 = delete.
- upd_idx  in  IDX_NBITS  slot to update.
- upd_time  in  TIME_NBITS  lifetime; 0 selects default_sub_exp_time.
- rd_idx  in  IDX_NBITS  lookup slot.
- rd_valid  out  1  registered: slot valid.
- rd_time  out  TIME_NBITS  registered: remaining lifetime.
- exp_valid  out  1  expiry event valid.
- exp_idx  out  IDX_NBITS  expired slot.
- exp_ready  in  1  consumer accepts the expiry event.
- busy  out  1  sweep in progress.

Behaviour:
- Reset (synchronous, active-high):
  - All valid bits and lifetimes cleared.
  - Prescaler, sweep index and pending flag cleared.
  - FSM set to IDLE.
  - All outputs 0.
  - Reset mid-sweep or mid-EMIT drops the event without handshake completion.
- Prescaler:
  - Counts clk_div pulses 0..TICK_DIV-1.
  - Wrap produces an internal tick.
  - A tick arriving while the FSM is not IDLE sets tick_pend. A second tick while tick_pend is set is dropped.
- FSM states: IDLE, SWEEP, EMIT.
- IDLE:
  - tick or tick_pend -> SWEEP, with idx=0, tick_pend cleared, busy=1 from the next cycle.
- SWEEP (one slot per cycle, slot idx):
  - Slot invalid, or lifetime 0 (permanent entry): no change.
  - Lifetime > 1: decrement.
  - Lifetime == 1: clear valid and lifetime to 0; exp_valid=1 and exp_idx=idx registered next cycle; -> EMIT.
  - Otherwise idx==SUB_ENTRIES-1 -> IDLE, else idx+1.
- EMIT:
  - Hold exp_valid/exp_idx stable until exp_ready.
  - On the exp_valid&exp_ready cycle: drop exp_valid; resume SWEEP at idx+1, or go IDLE after the last slot.
  - Aging is stalled while in EMIT.
- Updates (applied at the next edge, in any state):
  - set: valid=1; lifetime = upd_time, or default_sub_exp_time if upd_time==0.
  - If the resolved lifetime is 0, the entry is permanent and never expires.
  - delete: valid=0, lifetime=0.
  - Update to the slot being swept in the same cycle: the update wins; no decrement and no expiry for that slot this sweep.
  - Delete of a slot already emitted in EMIT does not retract the event.
- Lookup: rd_valid/rd_time reflect the table one cycle after rd_idx is presented; pre-update values in a collision cycle.
- Arithmetic: decrement is unsigned and never below 0. A full sweep takes SUB_ENTRIES cycles plus EMIT stall time.

Optional Feature:
- Macro ASA_AGING_STATS_EN.
- When defined, adds these outputs:
  - exp_cnt (32b): count of expiry handshakes.
  - tick_drop_cnt (16b): count of dropped ticks.
- Both counters:
  - Saturating.
  - Cleared by reset.
  - Cleared by a single-cycle stats_clr input; an increment coincident with clear yields 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Set slot 5 with upd_time=3, TICK_DIV=4, exp_ready=1 -> exp_valid with exp_idx=5 during the 3rd sweep; rd_valid for slot 5 reads 0 afterwards.
- upd_time=0 with default_sub_exp_time=2 on slot 9 -> expires on the 2nd sweep. Repeat with default 0 -> never expires after 10 sweeps.
- Slots 1, 2 and 63 with time 1, exp_ready held low for 20 cycles -> exp_valid stable at idx 1, busy=1. Release exp_ready -> events 1, 2, 63 in order, then IDLE.
- Refresh of slot 7 (time 4) in the exact cycle the sweep reaches slot 7 at lifetime 1 -> no expiry; rd_time=4.
- Two ticks during a long EMIT stall -> exactly one extra sweep. With ASA_AGING_STATS_EN: tick_drop_cnt=1.
- Reset asserted mid-EMIT -> exp_valid=0, busy=0 the next cycle; all rd_valid reads return 0.
